spi_mstr_param: RTL

SPI_MSTR_PARAM -- requirements
Module: spi_mstr_param

---
 rtl/spi_mstr_pkg.sv | 16 +
 rtl/spi_sclk_gen.sv | 35 +++
 rtl/spi_mstr_param.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_mstr_pkg.sv
// Shared types for the parameterised SPI master: FSM state encoding and
// slave-select width helper.
package spi_mstr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRONT = 2'd1,
      SHIFT = 2'd2,
      BACK  = 2'd3
   } spi_state_e;

   function automatic int sel_width(input int n_ss);
      return (n_ss > 1) ? $clog2(n_ss) : 1;
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider for the SPI master: free-running 0..P-1 phase counter with
// half-period, sample and shift strobes.
module spi_sclk_gen #(
   parameter int DIV_LOG2 = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic half_end,
   output logic smpl,
   output logic shft
);

   localparam logic [DIV_LOG2-1:0] HALF_M1 = {1'b0, {(DIV_LOG2-1){1'b1}}};
   localparam logic [DIV_LOG2-1:0] HALF    = {1'b1, {(DIV_LOG2-1){1'b0}}};
   localparam logic [DIV_LOG2-1:0] LAST    = '1;

   logic [DIV_LOG2-1:0] div;

   // natural binary wrap gives P-1 -> 0 with no idle cycle between bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div <= '0;
      else if (clr)
         div <= '0;
      else if (run)
         div <= div + 1'b1;
   end

   assign half_end = run && (div == HALF_M1);
   assign smpl     = run && (div == HALF);
   assign shft     = run && (div == LAST);

endmodule

// File: rtl/spi_mstr_param.sv
// Parameterised SPI master (SCLK idles high, sample on rise, shift on fall)
// with multiple slave selects and optional SS_n hold across words.
//
// state | meaning
// IDLE  | waiting for snd; SS_n may stay low if a held frame is open
// FRONT | SS_n low, SCLK high for half a period before the first bit
// SHIFT | DATA_W bit periods: SCLK low then high, sample, shift
// BACK  | SCLK high for half a period after the last bit
module spi_mstr_param
   import spi_mstr_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int DIV_LOG2 = 5,
   parameter  int N_SS     = 1,
   localparam int SEL_W    = sel_width(N_SS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              snd,
   input  logic [DATA_W-1:0] cmd,
   input  logic [SEL_W-1:0]  ss_sel,
   input  logic              keep_ss,
   input  logic              abort,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic [N_SS-1:0]   SS_n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] resp
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   spi_state_e        state_q;
   logic [DATA_W-1:0] sr_q;
   logic              smpl_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [SEL_W-1:0]  sel_q;
   logic              keep_q;
   logic              held_q;

   logic              half_end, smpl, shft, clr, run;
   logic              sel_ok;
   logic [SEL_W-1:0]  tgt;
   logic [N_SS-1:0]   ss_dec;

   assign run = (state_q != IDLE);
   assign clr = (state_q == IDLE) || abort ||
                (((state_q == FRONT) || (state_q == BACK)) && half_end);

   spi_sclk_gen #(.DIV_LOG2(DIV_LOG2)) u_sclk_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .run      (run),
      .half_end (half_end),
      .smpl     (smpl),
      .shft     (shft)
   );

   // an open held frame pins the target to the latched index
   assign sel_ok = held_q || (int'(ss_sel) < N_SS);
   assign tgt    = held_q ? sel_q : ss_sel;

   always_comb begin
      ss_dec = '1;
      for (int i = 0; i < N_SS; i++)
         if (tgt == SEL_W'(i)) ss_dec[i] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         SCLK    <= 1'b1;
         SS_n    <= '1;
         busy    <= 1'b0;
         done    <= 1'b0;
         sr_q    <= '0;
         smpl_q  <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= '0;
         keep_q  <= 1'b0;
         held_q  <= 1'b0;
      end else if (abort) begin
         state_q <= IDLE;
         SCLK    <= 1'b1;
         SS_n    <= '1;
         busy    <= 1'b0;
         cnt_q   <= '0;
         held_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (snd && sel_ok) begin
                  sr_q    <= cmd;
                  sel_q   <= tgt;
                  keep_q  <= keep_ss;
                  done    <= 1'b0;
                  SS_n    <= ss_dec;
                  busy    <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= FRONT;
               end
            end
            FRONT: begin
               if (half_end) begin
                  SCLK    <= 1'b0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (half_end) SCLK <= 1'b1;
               if (smpl) smpl_q <= MISO;
               if (shft) begin
                  sr_q <= {sr_q[DATA_W-2:0], smpl_q};
                  if (cnt_q == LAST_BIT) begin
                     cnt_q   <= '0;
                     state_q <= BACK;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     SCLK  <= 1'b0;
                  end
               end
            end
            BACK: begin
               if (half_end) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  held_q  <= keep_q;
                  if (!keep_q) SS_n <= '1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MOSI = sr_q[DATA_W-1];
   assign resp = sr_q;

endmodule
